// File: rtl/div_rem_unit_if.sv
// Operand/result bundle between the execute-stage issue logic and div_rem_unit.
// The master side issues requests; the slave side is the divider.
interface div_rem_unit_if #(
    parameter int DATAWIDTH = 32
);
    logic                 Start;
    logic                 Kill;
    logic [1:0]           Div_Op;
    logic [DATAWIDTH-1:0] Operand_1;
    logic [DATAWIDTH-1:0] Operand_2;
    logic                 Busy;
    logic                 Done;
    logic [DATAWIDTH-1:0] Out;

    modport master (
        output Start, Kill, Div_Op, Operand_1, Operand_2,
        input  Busy, Done, Out
    );

    modport slave (
        input  Start, Kill, Div_Op, Operand_1, Operand_2,
        output Busy, Done, Out
    );
endinterface

// File: rtl/div_rem_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish in one cycle; all others take DATAWIDTH+2.
module div_rem_unit #(
    parameter int DATAWIDTH = 32
) (
    input logic          Clk,
    input logic          Reset,
    div_rem_unit_if.slave bus
);
    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST    = CW'(W - 1);
    localparam logic [W-1:0]  INT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    dvsr_q, dvsr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    out_q, out_d;

    logic            is_signed, a_neg, b_neg, div_zero, overflow;
    logic [W-1:0]    a_mag, b_mag, fix_quo, fix_rem;
    logic [W:0]      shifted, trial;

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        count_d = count_q;
        out_d   = out_q;

        is_signed = ~bus.Div_Op[0];
        a_neg     = is_signed & bus.Operand_1[W-1];
        b_neg     = is_signed & bus.Operand_2[W-1];
        a_mag     = a_neg ? -bus.Operand_1 : bus.Operand_1;
        b_mag     = b_neg ? -bus.Operand_2 : bus.Operand_2;
        div_zero  = (bus.Operand_2 == '0);
        overflow  = is_signed && (bus.Operand_1 == INT_MIN) && (bus.Operand_2 == '1);

        // Bit W of the trial difference is the borrow: set means divisor did not fit.
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, dvsr_q};

        fix_quo = neg_q_q ? -quo_q : quo_q;
        fix_rem = neg_r_q ? -rem_q : rem_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.Start && !bus.Kill) begin
                    op_d    = bus.Div_Op;
                    neg_q_d = a_neg ^ b_neg;
                    neg_r_d = a_neg;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvsr_d  = b_mag;
                    count_d = '0;
                    if (div_zero) begin
                        out_d   = bus.Div_Op[1] ? bus.Operand_1 : '1;
                        state_d = DONE;
                    end else if (overflow) begin
                        out_d   = bus.Div_Op[1] ? '0 : bus.Operand_1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.Kill) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
                    quo_d   = {quo_q[W-2:0], ~trial[W]};
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) state_d = FIN;
                end
            end
            FIN: begin
                if (bus.Kill) begin
                    state_d = IDLE;
                end else begin
                    out_d   = op_q[1] ? fix_rem : fix_quo;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: the whole datapath is reset, not only the FSM, so Out reads 0 after Reset.
        if (Reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            op_q    <= op_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign bus.Busy = (state_q == CALC) || (state_q == FIN);
    assign bus.Done = (state_q == DONE);
    assign bus.Out  = out_q;
endmodule

// File: tb/tb_div_rem_unit.sv
// Self-checking bench for div_rem_unit: cycle-level behavioural model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_div_rem_unit;
    localparam int W = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
    localparam logic [W-1:0] INT_MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    div_rem_unit_if #(.DATAWIDTH(W)) bus ();
    div_rem_unit #(.DATAWIDTH(W)) dut (.Clk(clk), .Reset(reset), .bus(bus));

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension result semantics, computed with wide signed arithmetic.
    function automatic logic [W-1:0] model_result(input logic [1:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        longint sa, sb;
        if (b == '0) return op[1] ? a : '1;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? W'(sa % sb) : W'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit model_special(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        return (b == '0) || (!op[0] && a == INT_MIN && b == '1);
    endfunction

    // Model: an accepted op finishes W+1 edges later unless killed; specials finish at once.
    int             m_left = 0;
    bit             m_done = 1'b0;
    logic [W-1:0]   m_out  = '0;
    logic [W-1:0]   m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_out  = '0;
        end else if (m_left > 0) begin
            m_done = 1'b0;
            if (bus.Kill) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_out  = m_pend;
                    m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (bus.Start && !bus.Kill) begin
                if (model_special(bus.Div_Op, bus.Operand_1, bus.Operand_2)) begin
                    m_out  = model_result(bus.Div_Op, bus.Operand_1, bus.Operand_2);
                    m_done = 1'b1;
                end else begin
                    m_pend = model_result(bus.Div_Op, bus.Operand_1, bus.Operand_2);
                    m_left = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", W'(bus.Busy), W'(m_left > 0));
            check("model_done", W'(bus.Done), W'(m_done));
            check("model_out", bus.Out, m_out);
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
        int lat;
        bit busy_seen;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Div_Op = op;
        bus.Operand_1 = a;
        bus.Operand_2 = b;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Operand_1 = $urandom;
        bus.Operand_2 = $urandom;
        lat = 1;
        busy_seen = bus.Busy;
        while (!bus.Done && lat < 100) begin
            @(negedge clk);
            lat++;
            busy_seen |= bus.Busy;
        end
        check({name, "_lat"}, W'(lat), W'(exp_lat));
        check({name, "_out"}, bus.Out, exp);
        if (exp_lat == 1) check({name, "_nobusy"}, W'(busy_seen), '0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom % 8)
            0: return '0;
            1: return '1;
            2: return INT_MIN;
            3: return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat, done_cnt;
        bus.Start = 1'b0;
        bus.Kill = 1'b0;
        bus.Div_Op = OP_DIVU;
        bus.Operand_1 = '0;
        bus.Operand_2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        check("reset_busy", W'(bus.Busy), '0);
        check("reset_done", W'(bus.Done), '0);
        check("reset_out", bus.Out, '0);

        check("pin_model_div", model_result(OP_DIV, -32'sd7, 32'd2), 32'hFFFF_FFFD);
        check("pin_model_rem", model_result(OP_REM, 32'd7, -32'sd2), 32'h0000_0001);
        check("pin_model_ovf", model_result(OP_DIV, INT_MIN, '1), INT_MIN);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("div_m7_2", OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("rem_7_m2", OP_REM, 32'd7, -32'sd2, 32'd1, 34);
        run_op("div_7_m2", OP_DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD, 34);
        run_op("div_m8_m3", OP_DIV, -32'sd8, -32'sd3, 32'd2, 34);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", OP_DIV, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1);
        run_op("rem_ovf", OP_REM, INT_MIN, 32'hFFFF_FFFF, 32'd0, 1);

        // Kill on the 10th cycle of a DIVU; Out must keep the previous result (0).
        @(negedge clk);
        bus.Start = 1'b1; bus.Div_Op = OP_DIVU; bus.Operand_1 = 32'd1000; bus.Operand_2 = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        bus.Kill = 1'b1;
        @(negedge clk);
        bus.Kill = 1'b0;
        check("kill_busy", W'(bus.Busy), '0);
        check("kill_out", bus.Out, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done) done_cnt++;
        end
        check("kill_no_done", W'(done_cnt), '0);
        run_op("after_kill", OP_DIVU, 32'd1000, 32'd3, 32'd333, 34);

        // Start held high: second op accepted in the DONE cycle of the first.
        @(negedge clk);
        bus.Start = 1'b1; bus.Div_Op = OP_DIVU; bus.Operand_1 = 32'd100; bus.Operand_2 = 32'd7;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.Done && lat < 100);
        check("b2b_first_lat", W'(lat), 32'd34);
        check("b2b_first_out", bus.Out, 32'd14);
        bus.Div_Op = OP_REMU; bus.Operand_1 = 32'd50; bus.Operand_2 = 32'd7;
        @(negedge clk);
        bus.Start = 1'b0;
        check("b2b_accept_busy", W'(bus.Busy), 32'd1);
        lat = 1;
        while (!bus.Done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_lat", W'(lat), 32'd34);
        check("b2b_second_out", bus.Out, 32'd1);

        // Reset in the middle of CALC.
        @(negedge clk);
        bus.Start = 1'b1; bus.Div_Op = OP_DIVU; bus.Operand_1 = 32'd999; bus.Operand_2 = 32'd10;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", W'(bus.Busy), '0);
        check("midreset_done", W'(bus.Done), '0);
        check("midreset_out", bus.Out, '0);

        // Random traffic including Start-while-Busy and occasional Kill.
        repeat (8000) begin
            @(negedge clk);
            bus.Start = ($urandom % 4) == 0;
            bus.Kill = ($urandom % 64) == 0;
            bus.Div_Op = 2'($urandom);
            bus.Operand_1 = pick_operand();
            bus.Operand_2 = pick_operand();
        end
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Kill = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
